// File: rtl/ghost_ai_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ghost_ai_ctrl
// Purpose  : Ghost movement controller -- step timing, MOVE/DECIDE/SETTLE turn
//            FSM with chase/random steering, screen wrap and stuck detection.
// Revision : 1.0 - initial release
// ============================================================================
module ghost_ai_ctrl #(
  parameter int          X_W        = 10,
  parameter int          Y_W        = 9,
  parameter int          X_INIT     = 200,
  parameter int          Y_INIT     = 146,
  parameter int          X_MAX      = 639,
  parameter int          Y_MAX      = 479,
  parameter logic [1:0]  DIR_INIT   = 2'b00,
  parameter int          STEP_DIV   = 131072,
  parameter int          SETTLE_CYC = 2,
  parameter int          MAX_TRY    = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           move_ok,
  input  logic [1:0]     mode,
  input  logic [X_W-1:0] target_x,
  input  logic [Y_W-1:0] target_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     direction,
  output logic           turning,
  output logic           moved,
  output logic           stuck
);

  localparam int c_cnt_w = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int c_set_w = $clog2(SETTLE_CYC + 1);
  localparam int c_att_w = (MAX_TRY > 0) ? $clog2(MAX_TRY + 1) : 1;
  localparam int c_d_w   = ((X_W > Y_W) ? X_W : Y_W) + 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STEP_DIV - 1);
  localparam logic [c_set_w-1:0] c_set_last = c_set_w'(SETTLE_CYC - 1);
  localparam logic [c_att_w-1:0] c_att_max  = c_att_w'(MAX_TRY);
  localparam logic [X_W-1:0]     c_x_max    = X_W'(X_MAX);
  localparam logic [Y_W-1:0]     c_y_max    = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]     c_x_init   = X_W'(X_INIT);
  localparam logic [Y_W-1:0]     c_y_init   = Y_W'(Y_INIT);
  localparam logic [15:0]        c_seed     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  localparam logic [1:0] c_st_move   = 2'd0;
  localparam logic [1:0] c_st_decide = 2'd1;
  localparam logic [1:0] c_st_settle = 2'd2;

  localparam logic [1:0] c_dir_up    = 2'b00;
  localparam logic [1:0] c_dir_down  = 2'b01;
  localparam logic [1:0] c_dir_left  = 2'b10;
  localparam logic [1:0] c_dir_right = 2'b11;

  localparam logic [1:0] c_mode_chase  = 2'b01;
  localparam logic [1:0] c_mode_fright = 2'b10;

  logic [c_cnt_w-1:0] r_cnt;
  logic [15:0]        r_lfsr;
  logic [1:0]         r_state;
  logic [c_set_w-1:0] r_settle;
  logic [c_att_w-1:0] r_att;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [1:0]         r_dir;
  logic [1:0]         r_mode;
  logic               r_moved;

  logic               w_tick;
  logic               w_fright_edge;
  logic               w_lfsr_fb;
  logic signed [X_W:0] w_dx;
  logic signed [Y_W:0] w_dy;
  logic [c_d_w-1:0]   w_adx;
  logic [c_d_w-1:0]   w_ady;
  logic [1:0]         w_greedy;
  logic [1:0]         w_cand;
  logic [1:0]         w_new_dir;
  logic [X_W-1:0]     w_x_nxt;
  logic [Y_W-1:0]     w_y_nxt;

  assign w_tick        = (r_cnt == c_cnt_last);
  assign w_fright_edge = (mode == c_mode_fright) && (r_mode != c_mode_fright);
  assign w_lfsr_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Chase deltas are one bit wider than the coordinates so the sign survives.
  assign w_dx  = $signed({1'b0, target_x}) - $signed({1'b0, r_x});
  assign w_dy  = $signed({1'b0, target_y}) - $signed({1'b0, r_y});
  assign w_adx = w_dx[X_W] ? c_d_w'($unsigned(-w_dx)) : c_d_w'($unsigned(w_dx));
  assign w_ady = w_dy[Y_W] ? c_d_w'($unsigned(-w_dy)) : c_d_w'($unsigned(w_dy));

  always_comb begin
    w_greedy = c_dir_right;
    if (w_adx >= w_ady) begin
      w_greedy = w_dx[X_W] ? c_dir_left : c_dir_right;
    end else begin
      w_greedy = w_dy[Y_W] ? c_dir_up : c_dir_down;
    end
  end

  always_comb begin
    w_cand = r_lfsr[1:0];
    if ((mode == c_mode_chase) && (r_att == '0)) begin
      w_cand = w_greedy;
    end
  end

  // Never reload the direction that just got blocked.
  assign w_new_dir = (w_cand == r_dir) ? (w_cand + 2'd1) : w_cand;

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    case (r_dir)
      c_dir_up:    w_y_nxt = (r_y == '0)      ? c_y_max : (r_y - 1'b1);
      c_dir_down:  w_y_nxt = (r_y == c_y_max) ? '0      : (r_y + 1'b1);
      c_dir_left:  w_x_nxt = (r_x == '0)      ? c_x_max : (r_x - 1'b1);
      default:     w_x_nxt = (r_x == c_x_max) ? '0      : (r_x + 1'b1);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_lfsr   <= c_seed;
      r_state  <= c_st_settle;
      r_settle <= '0;
      r_att    <= '0;
      r_x      <= c_x_init;
      r_y      <= c_y_init;
      r_dir    <= DIR_INIT;
      r_mode   <= 2'b00;
      r_moved  <= 1'b0;
    end else if (en) begin
      r_cnt   <= w_tick ? '0 : (r_cnt + 1'b1);
      r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};
      r_mode  <= mode;
      r_moved <= 1'b0;
      // Entering frightened reverses course and pre-empts any step or turn.
      if (w_fright_edge) begin
        r_dir    <= r_dir ^ 2'b01;
        r_state  <= c_st_settle;
        r_settle <= '0;
      end else begin
        case (r_state)
          c_st_move: begin
            if (!move_ok) begin
              r_state <= c_st_decide;
            end else if (w_tick) begin
              r_x     <= w_x_nxt;
              r_y     <= w_y_nxt;
              r_moved <= 1'b1;
              r_att   <= '0;
            end
          end
          c_st_decide: begin
            r_dir    <= w_new_dir;
            r_state  <= c_st_settle;
            r_settle <= '0;
            if (r_att < c_att_max) begin
              r_att <= r_att + 1'b1;
            end
          end
          c_st_settle: begin
            if (r_settle == c_set_last) begin
              r_state <= move_ok ? c_st_move : c_st_decide;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          default: begin
            r_state  <= c_st_settle;
            r_settle <= '0;
          end
        endcase
      end
    end else begin
      r_moved <= 1'b0;
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign direction = r_dir;
  assign turning   = (r_state == c_st_decide) || (r_state == c_st_settle);
  assign moved     = r_moved & en;
  assign stuck     = (r_att >= c_att_max);

endmodule
`default_nettype wire

// File: tb/tb_ghost_ai_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_ai_ctrl
// Purpose  : Vector table, corner sequences and randomized reference-model run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghost_ai_ctrl;
  localparam int XW = 10, YW = 9, XMAX = 639, YMAX = 479, XINIT = 200, YINIT = 146;
  localparam int STEP = 4, SETTLE = 2, TRY = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          move_ok = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [XW-1:0] target_x = '0;
  logic [YW-1:0] target_y = '0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    direction;
  logic          turning, moved, stuck;
  logic [23:0]   dut_vec;

  ghost_ai_ctrl #(
    .X_W(XW), .Y_W(YW), .X_INIT(XINIT), .Y_INIT(YINIT), .X_MAX(XMAX), .Y_MAX(YMAX),
    .DIR_INIT(2'b00), .STEP_DIV(STEP), .SETTLE_CYC(SETTLE), .MAX_TRY(TRY),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .move_ok(move_ok), .mode(mode),
    .target_x(target_x), .target_y(target_y), .x(x), .y(y),
    .direction(direction), .turning(turning), .moved(moved), .stuck(stuck)
  );

  always #5 clk = ~clk;
  assign dut_vec = {x, y, direction, turning, moved, stuck};

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {PH_WALK, PH_PICK, PH_WAIT} phase_t;
  phase_t      m_phase;
  int          m_x, m_y, m_dir, m_tries, m_waited, m_en_cycles, m_prev_mode;
  bit [15:0]   m_lfsr;
  bit          m_moved;

  typedef struct {
    bit rs; bit e; bit ok; int md; int tx; int ty;
    int ex; int ey; int ed; bit et; bit em; bit es;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rs, bit e, bit ok, int md, int tx, int ty,
                              int ex, int ey, int ed, bit et, bit em, bit es);
    vec_t v;
    v.rs = rs; v.e = e; v.ok = ok; v.md = md; v.tx = tx; v.ty = ty;
    v.ex = ex; v.ey = ey; v.ed = ed; v.et = et; v.em = em; v.es = es;
    tbl.push_back(v);
  endfunction

  function automatic logic [23:0] tv(int ex, int ey, int ed, bit et, bit em, bit es);
    return {10'(ex), 9'(ey), 2'(ed), et, em, es};
  endfunction

  function automatic logic [23:0] mvec();
    return {10'(m_x), 9'(m_y), 2'(m_dir), (m_phase != PH_WALK), (m_moved & en), (m_tries >= TRY)};
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit [15:0] lfsr_adv(bit [15:0] l);
    bit [15:0] b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = XINIT; m_y = YINIT; m_dir = 0; m_phase = PH_WAIT; m_waited = 0;
    m_tries = 0; m_lfsr = 16'hACE1; m_en_cycles = 0; m_prev_mode = 0; m_moved = 0;
  endtask

  task automatic model_edge(input bit e, input bit ok, input int md, input int tx, input int ty);
    bit tick;
    int cand, dx, dy;
    bit [15:0] l_now;
    m_moved = 0;
    if (!e) return;
    tick = (m_en_cycles % STEP) == (STEP - 1);
    m_en_cycles++;
    l_now  = m_lfsr;
    m_lfsr = lfsr_adv(m_lfsr);
    if (md == 2 && m_prev_mode != 2) begin
      m_dir = m_dir ^ 1; m_phase = PH_WAIT; m_waited = 0;
    end else if (m_phase == PH_WALK) begin
      if (!ok) m_phase = PH_PICK;
      else if (tick) begin
        case (m_dir)
          0: m_y = (m_y + YMAX) % (YMAX + 1);
          1: m_y = (m_y + 1) % (YMAX + 1);
          2: m_x = (m_x + XMAX) % (XMAX + 1);
          default: m_x = (m_x + 1) % (XMAX + 1);
        endcase
        m_moved = 1; m_tries = 0;
      end
    end else if (m_phase == PH_PICK) begin
      if (md == 1 && m_tries == 0) begin
        dx = tx - m_x; dy = ty - m_y;
        if (iabs(dx) >= iabs(dy)) cand = (dx < 0) ? 2 : 3;
        else cand = (dy < 0) ? 0 : 1;
      end else cand = int'(l_now & 16'd3);
      if (cand == m_dir) cand = (cand + 1) % 4;
      m_dir = cand;
      m_tries = (m_tries < TRY) ? m_tries + 1 : TRY;
      m_phase = PH_WAIT; m_waited = 0;
    end else begin
      m_waited++;
      if (m_waited == SETTLE) m_phase = ok ? PH_WALK : PH_PICK;
    end
    m_prev_mode = md;
  endtask

  task automatic cyc(input bit e, input bit ok, input int md, input int tx, input int ty);
    en = e; move_ok = ok; mode = 2'(md); target_x = XW'(tx); target_y = YW'(ty);
    @(posedge clk);
    model_edge(e, ok, md, tx, ty);
    #1 check("cycle_model", dut_vec, mvec());
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1 check("async_reset", dut_vec, tv(XINIT, YINIT, 0, 1, 0, 0));
    @(posedge clk);
    #1 check("reset_hold", dut_vec, tv(XINIT, YINIT, 0, 1, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset release into SETTLE, then one step up every STEP cycles
    add(0,1,1,0,0,0,   200,146,0,1,0,0);
    add(0,1,1,0,0,0,   200,146,0,0,0,0);
    add(0,1,1,0,0,0,   200,146,0,0,0,0);
    add(0,1,1,0,0,0,   200,145,0,0,1,0);
    add(0,1,1,0,0,0,   200,145,0,0,0,0);
    add(0,1,1,0,0,0,   200,145,0,0,0,0);
    add(0,1,1,0,0,0,   200,145,0,0,0,0);
    add(0,1,1,0,0,0,   200,144,0,0,1,0);
    // Fresh reset; chase target (250,150) while blocked heading up
    add(1,1,0,1,250,150, 200,146,0,1,0,0);
    add(0,1,0,1,250,150, 200,146,0,1,0,0);
    add(0,1,0,1,250,150, 200,146,3,1,0,0);
    add(0,1,1,1,250,150, 200,146,3,1,0,0);
    add(0,1,1,1,250,150, 200,146,3,0,0,0);
    add(0,1,1,1,250,150, 200,146,3,0,0,0);
    add(0,1,1,1,250,150, 200,146,3,0,0,0);
    add(0,1,1,1,250,150, 201,146,3,0,1,0);
    // Frightened entry on a tick: reverse, settle, no step
    add(0,1,1,0,0,0,   201,146,3,0,0,0);
    add(0,1,1,0,0,0,   201,146,3,0,0,0);
    add(0,1,1,0,0,0,   201,146,3,0,0,0);
    add(0,1,1,2,0,0,   201,146,2,1,0,0);
    // Freeze mid-SETTLE, then finish the remaining settle cycle
    add(0,1,0,2,0,0,   201,146,2,1,0,0);
    for (int i = 0; i < 10; i++) add(0,0,0,2,0,0, 201,146,2,1,0,0);
    add(0,1,1,2,0,0,   201,146,2,0,0,0);
    add(0,1,1,2,0,0,   201,146,2,0,0,0);
    add(0,1,1,2,0,0,   200,146,2,0,1,0);

    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("initial_reset", dut_vec, tv(XINIT, YINIT, 0, 1, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      cyc(tbl[i].e, tbl[i].ok, tbl[i].md, tbl[i].tx, tbl[i].ty);
      check($sformatf("table_vec[%0d]", i), dut_vec,
            tv(tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].et, tbl[i].em, tbl[i].es));
    end

    // Walk left to x=0, wrap to X_MAX, reverse via frightened entry, wrap to 0
    k = 0;
    while (m_x != 0 && k < 1000) begin cyc(1, 1, 2, 0, 0); k++; end
    k = 0;
    while (m_x == 0 && k < 10) begin cyc(1, 1, 2, 0, 0); k++; end
    check("wrap_left", {14'd0, x}, 24'd639);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 2, 0, 0);
    check("fright_reverse", {22'd0, direction, turning}, {22'd0, 2'b11, 1'b1});
    k = 0;
    while (!m_moved && k < 20) begin cyc(1, 1, 2, 0, 0); k++; end
    check("wrap_right", {14'd0, x}, 24'd0);

    // Held blockage: stuck after the third attempt, persists while retrying
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (i == 7) check("stuck_before", {23'd0, stuck}, 24'd0);
    end
    check("stuck_rise", {23'd0, stuck}, 24'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 0);
      check("stuck_hold", {22'd0, turning, stuck}, 24'd3);
    end
    k = 0;
    cyc(1, 1, 0, 0, 0);
    while (!m_moved && k < 30) begin
      check("stuck_until_step", {23'd0, stuck}, 24'd1);
      cyc(1, 1, 0, 0, 0);
      k++;
    end
    check("stuck_clear", {22'd0, moved, stuck}, 24'd2);

    // Reset during a turn: first move_ok sample SETTLE cycles after release
    cyc(1, 0, 0, 0, 0);
    do_reset();
    cyc(1, 1, 0, 0, 0);
    check("post_reset_settle", {23'd0, turning}, 24'd1);
    cyc(1, 1, 0, 0, 0);
    check("post_reset_move", {23'd0, turning}, 24'd0);

    // Randomized run against the reference model
    begin
      int md, tx, ty;
      md = 0; tx = 300; ty = 200;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 399) == 0) do_reset();
        if ($urandom_range(0, 23) == 0) md = int'($urandom_range(0, 3));
        if ($urandom_range(0, 31) == 0) begin
          tx = int'($urandom_range(0, XMAX));
          ty = int'($urandom_range(0, YMAX));
        end
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, md, tx, ty);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ghost_ai_ctrl.md
GHOST_AI_CTRL -- requirements
Module: ghost_ai_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line; all SHALL be honoured:
  X_W, 10, x coordinate width
  Y_W, 9, y coordinate width
  X_INIT, 200, x after reset
  Y_INIT, 146, y after reset
  X_MAX, 639, highest x; x wraps 0<->X_MAX
  Y_MAX, 479, highest y; y wraps 0<->Y_MAX
  DIR_INIT, 2'b00, direction after reset
  STEP_DIV, 131072, clk cycles per step tick (>=2)
  SETTLE_CYC, 2, cycles allowed for the external collision checker after a direction load (>=1)
  MAX_TRY, 8, failed turn attempts before stuck asserts
  LFSR_SEED, 16'hACE1, LFSR reset value; 0 SHALL be replaced by 16'hACE1
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, all state on posedge
  rst  in  1  asynchronous, active-low reset
  en  in  1  1 = run, 0 = freeze all state
  move_ok  in  1  external checker: 1 = one step in current direction is clear
  mode  in  2  00 random, 01 chase, 10 frightened, 11 treated as 00
  target_x  in  X_W  chase target x
  target_y  in  Y_W  chase target y
  x  out  X_W  ghost x position
  y  out  Y_W  ghost y position
  direction  out  2  00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
  turning  out  1  high while FSM is in DECIDE or SETTLE
  moved  out  1  one-cycle pulse on each position update
  stuck  out  1  high while attempt count >= MAX_TRY

Function
REQ-003 Step counter SHALL count 0..STEP_DIV-1 while en=1, then wrap to 0; tick = (counter == STEP_DIV-1).
REQ-004 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, SHALL advance once per cycle while en=1.
REQ-005 en=0 SHALL hold the counter, LFSR, FSM, position, direction and attempt count; moved SHALL be 0.
REQ-006 FSM states SHALL be MOVE, DECIDE and SETTLE.
REQ-007 MOVE, move_ok=0: go to DECIDE; no step taken that cycle, even on a tick.
REQ-008 MOVE, move_ok=1 and tick: step 1 pixel in direction; moved=1 on the next cycle only; attempt count cleared.
REQ-009 Wrap: x=0 moving left -> X_MAX; x=X_MAX moving right -> 0; y follows the same rule with Y_MAX.
REQ-010 DECIDE lasts exactly one cycle, loads a new direction, then goes to SETTLE; the attempt count increments (saturating at MAX_TRY).
REQ-011 Candidate direction by mode:
  random/frightened: LFSR[1:0].
  chase, attempt 0: greedy; compare |dx| = |target_x-x| with |dy| = |target_y-y|; horizontal if |dx| >= |dy|, else vertical; sign of the difference picks the side.
  chase, attempt >0: LFSR[1:0].
REQ-012 If the candidate equals the current (blocked) direction, the loaded direction SHALL be candidate+1 mod 4.
REQ-013 SETTLE SHALL wait SETTLE_CYC cycles, then sample move_ok: 1 -> MOVE; 0 -> DECIDE.
REQ-014 Ticks during DECIDE/SETTLE SHALL be ignored; position is unchanged.
REQ-015 A mode transition into 10 from any other mode (mode registered; edge detected) SHALL, in the same cycle, set direction to direction^2'b01 and enter SETTLE; this SHALL override a simultaneous step or DECIDE, and the attempt count SHALL NOT change.
REQ-016 Coordinate arithmetic SHALL be unsigned at X_W/Y_W; differences for chase SHALL be computed at width+1 signed.
REQ-017 stuck SHALL stay high until a successful step clears the attempt count; retries SHALL continue while stuck.

Reset
REQ-018 While rst=0, asynchronously:
  x=X_INIT, y=Y_INIT, direction=DIR_INIT
  FSM=SETTLE with settle count 0
  step counter 0, LFSR=LFSR_SEED, attempt count 0
  moved=0, stuck=0, registered mode=00
REQ-019 Reset asserted mid-operation SHALL discard the step or turn in progress; after release the first move_ok sample SHALL occur SETTLE_CYC cycles later.

Verification (STEP_DIV=4, SETTLE_CYC=2, MAX_TRY=3, X_MAX=639, Y_MAX=479)
REQ-020 Reset release, move_ok=1, mode=00, en=1 -> SETTLE 2 cycles, then MOVE; y decrements 146->145 on the first tick; one moved pulse per 4 cycles.
REQ-021 x=0, direction=10, move_ok=1, tick -> x=639; x=639, direction=11 -> x=0.
REQ-022 Chase, x=200, y=146, target (250,150), blocked while heading up -> loaded direction 11; move_ok=1 after 2 cycles -> MOVE; x increments.
REQ-023 move_ok held 0 -> DECIDE/SETTLE loop; stuck rises after the 3rd attempt; move_ok=1 then a step -> stuck=0, attempt count 0.
REQ-024 Mode 00->10 on the same cycle as a tick, direction=11 -> direction=10, state SETTLE, no step taken, moved=0.
REQ-025 en=0 for 10 cycles mid-SETTLE -> all outputs and the LFSR are unchanged; resuming continues the remaining settle count.
